// File: rtl/pipeline_pkg.sv
// Shared fetch-stage types: FSM states, entry bundle
// and opcode constants used by the IF stage and its buffer.
package pipeline_pkg;

    localparam int XLEN = 32;

    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_BNE = 6'b000101;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_ROOM,
        HALT
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc4;
        logic            branch;
    } fetch_entry_t;

    function automatic logic is_branch(input logic [XLEN-1:0] word);
        return (word[31:26] == OP_BEQ) || (word[31:26] == OP_BNE);
    endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory fetch bus: one request outstanding,
// completed by a single-cycle ready/data response.
interface if_fetch_unit_if;
    import pipeline_pkg::*;

    logic            Out_MemReq;
    logic [XLEN-1:0] Out_MemAddr;
    logic            In_MemRdy;
    logic [XLEN-1:0] In_MemData;

    modport master (
        output Out_MemReq,
        output Out_MemAddr,
        input  In_MemRdy,
        input  In_MemData
    );

    modport slave (
        input  Out_MemReq,
        input  Out_MemAddr,
        output In_MemRdy,
        output In_MemData
    );

endinterface

// File: rtl/fetch_skid_buffer.sv
// Two-entry in-order holding buffer: head feeds IF/ID,
// skid parks a response that arrived while head was stalled.
module fetch_skid_buffer
    import pipeline_pkg::*;
(
    input  logic         Clock,
    input  logic         Reset,
    input  logic         clear,
    input  logic         push,
    input  logic         pop,
    input  fetch_entry_t push_data,
    output fetch_entry_t head,
    output logic         head_valid,
    output logic         skid_valid
);

    fetch_entry_t head_q;
    fetch_entry_t skid_q;
    logic         head_v_q;
    logic         skid_v_q;
    logic         pop_ok;

    assign pop_ok     = pop && head_v_q;
    assign head       = head_q;
    assign head_valid = head_v_q;
    assign skid_valid = skid_v_q;

    // Entries are zeroed when vacated so an empty head reads as 0.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            head_q   <= '0;
            skid_q   <= '0;
            head_v_q <= 1'b0;
            skid_v_q <= 1'b0;
        end else if (clear) begin
            head_q   <= '0;
            skid_q   <= '0;
            head_v_q <= 1'b0;
            skid_v_q <= 1'b0;
        end else if (pop_ok) begin
            if (skid_v_q) begin
                head_q <= skid_q;
                if (push) begin
                    skid_q <= push_data;
                end else begin
                    skid_q   <= '0;
                    skid_v_q <= 1'b0;
                end
            end else if (push) begin
                head_q <= push_data;
            end else begin
                head_q   <= '0;
                head_v_q <= 1'b0;
            end
        end else if (push) begin
            if (!head_v_q) begin
                head_q   <= push_data;
                head_v_q <= 1'b1;
            end else begin
                skid_q   <= push_data;
                skid_v_q <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches one word at a time
// and hands buffered instructions to IF/ID; handles redirects.
module if_fetch_unit
    import pipeline_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
    parameter logic [XLEN-1:0] HALT_INSTR = 32'hFFFF_FFFF
) (
    input  logic            Clock,
    input  logic            Reset,
    input  logic            In_Stall,
    input  logic            In_Redirect,
    input  logic [XLEN-1:0] In_RedirectAddr,
    if_fetch_unit_if.master mem,
    output logic [XLEN-1:0] Out_Instruction,
    output logic [XLEN-1:0] Out_PCAdder,
    output logic            Out_Branch,
    output logic            Out_Valid,
    output logic            Out_Flush,
    output logic            Out_Halted
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] hold_q, hold_d;
    logic [XLEN-1:0] pc_plus4;
    logic            discard_q, discard_d;
    logic            requesting;
    logic            take;
    logic            drain;
    logic            buf_valid;
    logic            skid_valid;
    fetch_entry_t    push_entry;
    fetch_entry_t    head;

    // A discarded wrong-path request keeps its original address
    // until memory answers; the PC already holds the new target.
    assign requesting      = (state_q == REQ) && !skid_valid;
    assign mem.Out_MemReq  = requesting;
    assign mem.Out_MemAddr = discard_q ? hold_q : pc_q;

    assign pc_plus4 = pc_q + 32'd4;
    assign drain    = buf_valid && !In_Stall;
    assign take     = requesting && mem.In_MemRdy
                   && !discard_q && !In_Redirect;

    assign push_entry.instr  = mem.In_MemData;
    assign push_entry.pc4    = pc_plus4;
    assign push_entry.branch = is_branch(mem.In_MemData);

    fetch_skid_buffer u_buf (
        .Clock      (Clock),
        .Reset      (Reset),
        .clear      (In_Redirect),
        .push       (take),
        .pop        (drain),
        .push_data  (push_entry),
        .head       (head),
        .head_valid (buf_valid),
        .skid_valid (skid_valid)
    );

    // Next state, PC and discard tracking; redirect beats everything.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        hold_d    = hold_q;
        discard_d = discard_q;
        if (In_Redirect) begin
            state_d   = REQ;
            pc_d      = In_RedirectAddr & ~32'h3;
            hold_d    = mem.Out_MemAddr;
            discard_d = requesting && !mem.In_MemRdy;
        end else begin
            unique case (state_q)
                IDLE: state_d = REQ;
                REQ: begin
                    if (requesting && mem.In_MemRdy) begin
                        if (discard_q) begin
                            discard_d = 1'b0;
                        end else begin
                            pc_d = pc_plus4;
                            if (mem.In_MemData == HALT_INSTR)
                                state_d = HALT;
                            else if (buf_valid && !drain)
                                state_d = WAIT_ROOM;
                        end
                    end
                end
                WAIT_ROOM: if (drain) state_d = REQ;
                HALT: state_d = HALT;
            endcase
        end
    end

    // State, PC and discard registers.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC;
            hold_q    <= RESET_PC;
            discard_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            hold_q    <= hold_d;
            discard_q <= discard_d;
        end
    end

    assign Out_Instruction = head.instr;
    assign Out_PCAdder     = head.pc4;
    assign Out_Branch      = head.branch;
    assign Out_Valid       = buf_valid;
    assign Out_Flush       = In_Redirect;
    assign Out_Halted      = (state_q == HALT);

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios plus random traffic,
// checked against an in-order delivery model of the fetch stream.
module tb_if_fetch_unit;

    logic        Clock;
    logic        Reset;
    logic        In_Stall;
    logic        In_Redirect;
    logic [31:0] In_RedirectAddr;
    logic [31:0] Out_Instruction;
    logic [31:0] Out_PCAdder;
    logic        Out_Branch;
    logic        Out_Valid;
    logic        Out_Flush;
    logic        Out_Halted;

    if_fetch_unit_if mif ();

    if_fetch_unit dut (
        .Clock           (Clock),
        .Reset           (Reset),
        .In_Stall        (In_Stall),
        .In_Redirect     (In_Redirect),
        .In_RedirectAddr (In_RedirectAddr),
        .mem             (mif),
        .Out_Instruction (Out_Instruction),
        .Out_PCAdder     (Out_PCAdder),
        .Out_Branch      (Out_Branch),
        .Out_Valid       (Out_Valid),
        .Out_Flush       (Out_Flush),
        .Out_Halted      (Out_Halted)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int          n_chk = 0;
    int          n_err = 0;
    int          wait_cnt = -1;
    int          lat_fix = 0;
    int          lat_max = 0;
    logic        halt_on = 1'b0;
    logic        halted_exp = 1'b0;
    logic [31:0] exp_pc = 32'h0;
    logic        prev_req = 1'b0;
    logic        prev_rdy = 1'b0;
    logic [31:0] prev_addr = 32'h0;
    logic [31:0] snap;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Program image: a few fixed words, a halt slot, and a
    // default pattern that sprinkles beq/bne across addresses.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (halt_on && a == 32'hC) return 32'hFFFF_FFFF;
        if (a == 32'h100) return 32'h1000_0003;
        if (a == 32'h104) return 32'h2000_0001;
        case (a[4:2])
            3'd3:    return {6'b000100, a[27:2]};
            3'd5:    return {6'b000101, a[27:2]};
            default: return {6'b001000, a[27:2]};
        endcase
    endfunction

    // One cycle: memory responds, inputs are driven at the falling
    // edge, and any IF/ID capture at the next rising edge is checked
    // against the next address expected in program order.
    task automatic step(input logic stall,
                        input logic redir,
                        input logic [31:0] raddr);
        logic        rdy;
        logic [31:0] w;
        @(negedge Clock);
        if (prev_req && !prev_rdy) begin
            check("req_hold", 32'(mif.Out_MemReq), 32'd1);
            check("addr_hold", mif.Out_MemAddr, prev_addr);
        end
        if (Out_Halted)
            check("halt_noreq", 32'(mif.Out_MemReq), 32'd0);
        rdy = 1'b0;
        if (mif.Out_MemReq) begin
            if (wait_cnt < 0)
                wait_cnt = (lat_fix >= 0) ? lat_fix
                         : int'($urandom_range(lat_max, 0));
            rdy = (wait_cnt == 0);
            wait_cnt = rdy ? -1 : wait_cnt - 1;
        end
        mif.In_MemRdy   = rdy;
        mif.In_MemData  = rdy ? mem_word(mif.Out_MemAddr) : 32'h0;
        In_Stall        = stall;
        In_Redirect     = redir;
        In_RedirectAddr = raddr;
        #1;
        check("flush", 32'(Out_Flush), 32'(redir));
        if (redir) begin
            exp_pc     = {raddr[31:2], 2'b00};
            halted_exp = 1'b0;
        end else if (Out_Valid && !stall) begin
            w = mem_word(exp_pc);
            check("halt_order", 32'(halted_exp), 32'd0);
            check("instr", Out_Instruction, w);
            check("pc4", Out_PCAdder, exp_pc + 32'd4);
            check("branch", 32'(Out_Branch),
                  32'(w[31:26] == 6'b000100 || w[31:26] == 6'b000101));
            if (w == 32'hFFFF_FFFF) halted_exp = 1'b1;
            exp_pc = exp_pc + 32'd4;
        end
        prev_req  = mif.Out_MemReq;
        prev_rdy  = rdy;
        prev_addr = mif.Out_MemAddr;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"}, 32'(mif.Out_MemReq), 32'd0);
        check({tag, "_addr"}, mif.Out_MemAddr, 32'h0);
        check({tag, "_valid"}, 32'(Out_Valid), 32'd0);
        check({tag, "_instr"}, Out_Instruction, 32'h0);
        check({tag, "_pc4"}, Out_PCAdder, 32'h0);
        check({tag, "_branch"}, 32'(Out_Branch), 32'd0);
        check({tag, "_halted"}, 32'(Out_Halted), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset           = 1'b1;
        In_Stall        = 1'b0;
        In_Redirect     = 1'b0;
        In_RedirectAddr = 32'h0;
        mif.In_MemRdy   = 1'b0;
        mif.In_MemData  = 32'h0;

        // Reset values, then back-to-back fetch with ready tied high.
        repeat (2) @(negedge Clock);
        #1;
        check_reset_outputs("rst");
        Reset = 1'b0;
        check("idle_req", 32'(mif.Out_MemReq), 32'd0);
        for (int k = 1; k <= 4; k++) begin
            step(1'b0, 1'b0, 32'h0);
            check("t1_addr", mif.Out_MemAddr, 32'(4 * (k - 1)));
            check("t1_valid", 32'(Out_Valid), 32'(k >= 2));
            if (k >= 2)
                check("t1_pc4", Out_PCAdder, 32'(4 * (k - 1)));
        end

        // Stall three cycles: head stays put, requests stop once skid fills.
        step(1'b1, 1'b0, 32'h0);
        snap = Out_Instruction;
        check("t2_valid", 32'(Out_Valid), 32'd1);
        for (int k = 0; k < 2; k++) begin
            step(1'b1, 1'b0, 32'h0);
            check("t2_req", 32'(mif.Out_MemReq), 32'd0);
            check("t2_hold", Out_Instruction, snap);
        end
        repeat (6) step(1'b0, 1'b0, 32'h0);

        // Redirect to 0x43 while the 0x8 fetch is outstanding.
        step(1'b0, 1'b1, 32'h8);
        lat_fix = 2;
        step(1'b0, 1'b0, 32'h0);
        check("t3_addr8", mif.Out_MemAddr, 32'h8);
        step(1'b0, 1'b1, 32'h43);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b0, 32'h0);
            if (mif.Out_MemAddr != 32'h8) break;
        end
        check("t3_new_addr", mif.Out_MemAddr, 32'h40);
        check("t3_new_req", 32'(mif.Out_MemReq), 32'd1);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 32'h0);
            if (Out_Valid) break;
        end
        check("t3_first_pc4", Out_PCAdder, 32'h44);

        // Branch decode on fixed words.
        lat_fix = 0;
        step(1'b0, 1'b1, 32'h100);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 32'h0);
            if (Out_Valid) break;
        end
        check("t4_beq_pc4", Out_PCAdder, 32'h104);
        check("t4_beq_instr", Out_Instruction, 32'h1000_0003);
        check("t4_beq", 32'(Out_Branch), 32'd1);
        step(1'b0, 1'b0, 32'h0);
        check("t4_other_instr", Out_Instruction, 32'h2000_0001);
        check("t4_other", 32'(Out_Branch), 32'd0);

        // Halt word at 0xC, then restart with a redirect.
        halt_on = 1'b1;
        step(1'b0, 1'b1, 32'h0);
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b0, 32'h0);
            if (halted_exp) break;
        end
        check("t5_halt_seen", 32'(halted_exp), 32'd1);
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b0, 32'h0);
            check("t5_halted", 32'(Out_Halted), 32'd1);
            check("t5_noreq", 32'(mif.Out_MemReq), 32'd0);
        end
        halt_on = 1'b0;
        step(1'b0, 1'b1, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        check("t5_resume_req", 32'(mif.Out_MemReq), 32'd1);
        check("t5_resume_addr", mif.Out_MemAddr, 32'h0);
        check("t5_unhalted", 32'(Out_Halted), 32'd0);

        // Asynchronous reset mid-request while stalled.
        lat_fix = 3;
        step(1'b0, 1'b1, 32'h20);
        repeat (8) step(1'b1, 1'b0, 32'h0);
        check("t6_pre_valid", 32'(Out_Valid), 32'd1);
        #2;
        Reset = 1'b1;
        #1;
        check_reset_outputs("t6");
        @(negedge Clock);
        In_Stall      = 1'b0;
        In_Redirect   = 1'b0;
        mif.In_MemRdy = 1'b0;
        exp_pc        = 32'h0;
        wait_cnt      = -1;
        prev_req      = 1'b0;
        halted_exp    = 1'b0;
        lat_fix       = 0;
        Reset         = 1'b0;
        step(1'b0, 1'b0, 32'h0);
        check("t6_restart_req", 32'(mif.Out_MemReq), 32'd1);
        check("t6_restart_addr", mif.Out_MemAddr, 32'h0);
        repeat (4) step(1'b0, 1'b0, 32'h0);

        // PC wrap, with low redirect bits masked off.
        step(1'b0, 1'b1, 32'hFFFF_FFFA);
        step(1'b0, 1'b0, 32'h0);
        check("t7_addr", mif.Out_MemAddr, 32'hFFFF_FFF8);
        step(1'b0, 1'b0, 32'h0);
        check("t7_pc4_a", Out_PCAdder, 32'hFFFF_FFFC);
        step(1'b0, 1'b0, 32'h0);
        check("t7_pc4_b", Out_PCAdder, 32'h0);
        check("t7_wrap_addr", mif.Out_MemAddr, 32'h0);

        // Random stalls, redirects and memory latency.
        lat_fix = -1;
        for (int i = 0; i < 1500; i++) begin
            logic        st;
            logic        rd;
            logic [31:0] ra;
            if (i % 100 == 0) lat_max = int'($urandom_range(3, 0));
            st = ($urandom_range(99, 0) < 30);
            rd = ($urandom_range(99, 0) < 4);
            if ($urandom_range(9, 0) == 0)
                ra = 32'hFFFF_FFF0 | 32'($urandom_range(15, 0));
            else
                ra = $urandom() & 32'h0000_0FFF;
            step(st, rd, ra);
        end
        repeat (10) step(1'b0, 1'b0, 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage and producer side of the IF/ID pipeline register.
- Owns the PC and issues word fetches to instruction memory over a req/rdy handshake, with one request outstanding at a time.
- Buffers one returned instruction and presents it, with PC+4 and a branch-class flag, for IF/ID to capture when IF/ID is enabled.
- Handles redirects from later stages by discarding wrong-path fetches and asserting the IF/ID flush.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- HALT_INSTR, 32'hFFFF_FFFF, encoding that stops fetching once buffered.

Ports:
- Clock  in  1  sole clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- In_Stall  in  1  downstream stall; IF/ID Enable = !In_Stall.
- In_Redirect  in  1  taken branch/jump resolved downstream.
- In_RedirectAddr  in  32  new PC on redirect.
- Out_MemReq  out  1  fetch request, held until accepted.
- Out_MemAddr  out  32  word address (PC), stable while Out_MemReq=1.
- In_MemRdy  in  1  response valid; completes the request this cycle.
- In_MemData  in  32  instruction word, valid with In_MemRdy.
- Out_Instruction  out  32  buffered instruction (0 when buffer empty).
- Out_PCAdder  out  32  PC of buffered instruction + 4.
- Out_Branch  out  1  buffered opcode[31:26] is 6'b000100 (beq) or 6'b000101 (bne).
- Out_Valid  out  1  buffer holds a valid instruction.
- Out_Flush  out  1  IF/ID flush; combinational = In_Redirect.
- Out_Halted  out  1  halt instruction reached; fetching stopped.

Behaviour:
- Reset (async, any state) sets:
  - PC=RESET_PC, state=IDLE.
  - Buffer empty; Out_Instruction=0, Out_PCAdder=0, Out_Branch=0, Out_Valid=0.
  - Out_MemReq=0, discard flag=0, Out_Halted=0.
- FSM states:
  - IDLE: one cycle after reset deassertion, then REQ.
  - REQ: Out_MemReq=1, Out_MemAddr=PC.
  - WAIT_ROOM: response captured but buffer still occupied; no request issued.
  - HALT: no requests.
- Buffer drain: on any edge with Out_Valid=1 and In_Stall=0, IF/ID captures the entry and the buffer empties, unless refilled the same edge.
- REQ with In_MemRdy=1 and discard=0:
  - Instruction written to buffer; Out_PCAdder=PC+4; Out_Branch decoded from the word; Out_Valid=1; PC<=PC+4.
  - Allowed only if the buffer is empty or draining this edge.
  - If the buffer is full and stalled, the response is parked in a one-entry skid register and the FSM moves to WAIT_ROOM. The response is never lost.
- WAIT_ROOM: when the buffer drains, the skid entry moves to the buffer the same edge and the FSM returns to REQ. Peak throughput is one instruction per cycle when In_MemRdy is asserted combinationally.
- Halt: if the captured word == HALT_INSTR, it is still buffered and delivered. The FSM then goes to HALT, Out_Halted=1, PC frozen. Only Reset or In_Redirect leaves HALT.
- Redirect (In_Redirect=1 at an edge):
  - PC<=In_RedirectAddr.
  - Buffer and skid register cleared; Out_Valid=0; Out_Instruction=0.
  - FSM goes to REQ.
  - If a request is outstanding and In_MemRdy=0 that cycle, discard<=1.
  - If In_MemRdy=1 that same edge, the response is dropped and discard is not set.
- Discard: while discard=1, Out_MemReq stays high with the old address until In_MemRdy. That response is dropped, discard<=0, and the next cycle requests In_RedirectAddr. The address is never changed mid-request.
- Priority: Reset > In_Redirect > memory response > drain. Redirect wins over In_Stall; Out_Flush is asserted even while stalled.
- Arithmetic: PC+4 is modulo 2^32; 32'hFFFF_FFFC wraps to 0. PC[1:0] are forced to 0 on redirect.
- Out_MemReq never asserts in IDLE or HALT, or while the skid register is full.

Decomposition:
- Shared package pipeline_pkg: FSM state enum (IDLE, REQ, WAIT_ROOM, HALT), opcode constants OP_BEQ=6'b000100 and OP_BNE=6'b000101, width constant XLEN=32.
- One natural sub-module, fetch_skid_buffer: 2-entry (buffer + skid) holding {instr, pc4, branch}, with push/pop/clear ports. The FSM and PC stay in if_fetch_unit.

Test Plan:
- Reset release with In_MemRdy tied 1, no stall: Out_MemAddr steps 0,4,8,C on consecutive cycles; Out_PCAdder 4,8,C,10; Out_Valid=1 from cycle 2 after IDLE.
- Stall for 3 cycles with MemRdy=1: at most 2 instructions held; Out_Instruction stable; Out_MemReq drops while the skid is full. After release, delivery resumes in order with no gaps or duplicates.
- Redirect to 0x40 while a request to 0x8 is outstanding (MemRdy delayed 2 cycles):
  - Out_Flush=1 for 1 cycle; the 0x8 response is dropped.
  - Next Out_MemAddr=0x40; first delivered Out_PCAdder=0x44.
- Word 0x1000_0003 (beq) fetched: Out_Branch=1. Word 0x2000_0001: Out_Branch=0.
- HALT_INSTR at 0xC: delivered with Out_PCAdder=0x10, then Out_Halted=1 and no further Out_MemReq. Redirect to 0x0 resumes fetching.
- Reset asserted mid-request while stalled: all outputs return to reset values asynchronously (before the next edge). After release, fetch restarts at RESET_PC.
